// File: rtl/adc_capture_array.sv
// Triggered multi-channel ADC capture into per-channel RAM, replayed channel by
// channel onto one AXI-Stream master tagged with channel ID and per-channel tlast.
module adc_capture_array #(
   parameter int NUM_CH  = 4,
   parameter int DATA_W  = 128,
   parameter int DEPTH   = 1024,
   parameter int DECIM_W = 8
) (
   input  logic                                           pl_clk,
   input  logic                                           rst,
   input  logic                                           trigger,
   input  logic                                           flush,
   input  logic [NUM_CH-1:0]                              ch_enable,
   input  logic [$clog2(DEPTH):0]                         capture_len,
   input  logic [DECIM_W-1:0]                             decim,
   input  logic [NUM_CH*DATA_W-1:0]                       s_axis_tdata,
   input  logic [NUM_CH-1:0]                              s_axis_tvalid,
   output logic [NUM_CH-1:0]                              s_axis_tready,
   output logic [DATA_W-1:0]                              m_axis_tdata,
   output logic                                           m_axis_tvalid,
   input  logic                                           m_axis_tready,
   output logic                                           m_axis_tlast,
   output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] m_axis_tuser,
   output logic                                           busy,
   output logic                                           done
);

   localparam int AW   = $clog2(DEPTH);
   localparam int LW   = AW + 1;
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_READOUT, S_DONE} state_t;

   state_t                    state_q, state_d;
   logic                      trig_p0;
   logic [NUM_CH*DATA_W-1:0]  s_data_p0;
   logic [NUM_CH-1:0]         s_vld_p0;
   logic [NUM_CH-1:0]         en_q;
   logic [LW-1:0]             len_q, len_clip;
   logic [DECIM_W-1:0]        decim_q, dec_cnt;
   logic [LW-1:0]             wr_addr, rd_addr;
   logic [CH_W-1:0]           rd_ch, ch_p1;
   logic                      rd_pend;
   logic                      vld_p1, last_p1, fin_p1, m_fin;
   logic [NUM_CH*DATA_W-1:0]  rd_bus_p1;
   logic                      trig_edge, start, strobe, wr_en, wr_last;
   logic                      adv, rd_issue, rd_last, accept_fin;
   logic [CH_W:0]             first_ch, nxt_ch;

   // Returns {found, index} of the lowest enabled channel above cur.
   function automatic logic [CH_W:0] next_ch(input logic [NUM_CH-1:0] en, input int cur);
      logic [CH_W:0] r;
      r = '0;
      for (int k = NUM_CH - 1; k >= 0; k--)
         if (en[k] && (k > cur)) r = {1'b1, CH_W'(k)};
      return r;
   endfunction

   assign s_axis_tready = '1;
   assign busy          = (state_q == S_CAPTURE) || (state_q == S_READOUT);
   assign done          = (state_q == S_DONE);

   assign trig_edge  = trigger && !trig_p0;
   assign start      = (state_q == S_IDLE) && trig_edge && (|ch_enable);
   assign len_clip   = (capture_len > LW'(DEPTH)) ? LW'(DEPTH) : capture_len;
   assign strobe     = (state_q == S_CAPTURE) && (&(s_vld_p0 | ~en_q));
   assign wr_en      = strobe && (dec_cnt == '0);
   assign wr_last    = wr_en && (wr_addr == len_q - LW'(1));
   assign adv        = !m_axis_tvalid || m_axis_tready;
   assign rd_issue   = (state_q == S_READOUT) && rd_pend && adv;
   assign rd_last    = (rd_addr == len_q - LW'(1));
   assign first_ch   = next_ch(en_q, -1);
   assign nxt_ch     = next_ch(en_q, int'(rd_ch));
   assign accept_fin = m_axis_tvalid && m_axis_tready && m_fin;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (start) state_d = (len_clip == '0) ? S_DONE : S_CAPTURE;
         S_CAPTURE: if (wr_last) state_d = S_READOUT;
         S_READOUT: if (accept_fin) state_d = S_DONE;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
      if (flush) state_d = S_IDLE;
   end

   always_ff @(posedge pl_clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // p0: input registers
   always_ff @(posedge pl_clk) begin
      s_data_p0 <= s_axis_tdata;
   end

   always_ff @(posedge pl_clk) begin
      if (rst) begin
         trig_p0       <= 1'b0;
         s_vld_p0      <= '0;
         en_q          <= '0;
         len_q         <= '0;
         decim_q       <= '0;
         dec_cnt       <= '0;
         wr_addr       <= '0;
         rd_addr       <= '0;
         rd_ch         <= '0;
         rd_pend       <= 1'b0;
         vld_p1        <= 1'b0;
         last_p1       <= 1'b0;
         fin_p1        <= 1'b0;
         ch_p1         <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= '0;
         m_fin         <= 1'b0;
      end else begin
         trig_p0  <= trigger;
         s_vld_p0 <= s_axis_tvalid;
         if (start) begin
            en_q    <= ch_enable;
            len_q   <= len_clip;
            decim_q <= decim;
            dec_cnt <= '0;
            wr_addr <= '0;
         end
         if (strobe) dec_cnt <= (dec_cnt == decim_q) ? '0 : dec_cnt + DECIM_W'(1);
         if (wr_en) wr_addr <= wr_addr + LW'(1);
         // Read address generator walks enabled channels in ascending order.
         if ((state_q == S_CAPTURE) && wr_last) begin
            rd_pend <= first_ch[CH_W];
            rd_ch   <= first_ch[CH_W-1:0];
            rd_addr <= '0;
         end else if (rd_issue) begin
            if (!rd_last) begin
               rd_addr <= rd_addr + LW'(1);
            end else if (nxt_ch[CH_W]) begin
               rd_ch   <= nxt_ch[CH_W-1:0];
               rd_addr <= '0;
            end else begin
               rd_pend <= 1'b0;
            end
         end
         // p1: RAM read register; p2: output register. Both stall together.
         if (adv) begin
            vld_p1        <= rd_issue;
            last_p1       <= rd_last;
            fin_p1        <= rd_last && !nxt_ch[CH_W];
            ch_p1         <= rd_ch;
            m_axis_tvalid <= vld_p1;
            m_axis_tlast  <= last_p1;
            m_axis_tuser  <= ch_p1;
            m_fin         <= fin_p1;
         end
         if (flush) begin
            rd_pend       <= 1'b0;
            vld_p1        <= 1'b0;
            m_axis_tvalid <= 1'b0;
         end
      end
   end

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      logic [DATA_W-1:0] mem [DEPTH];
      logic [DATA_W-1:0] rd_q_p1;
      always_ff @(posedge pl_clk) begin
         if (wr_en && en_q[k]) mem[wr_addr[AW-1:0]] <= s_data_p0[k*DATA_W +: DATA_W];
         if (rd_issue) rd_q_p1 <= mem[rd_addr[AW-1:0]];
      end
      assign rd_bus_p1[k*DATA_W +: DATA_W] = rd_q_p1;
   end

   always_ff @(posedge pl_clk) begin
      if (rst)      m_axis_tdata <= '0;
      else if (adv) m_axis_tdata <= rd_bus_p1[int'(ch_p1)*DATA_W +: DATA_W];
   end

endmodule

// File: tb/tb_adc_capture_array.sv
// Randomised bench for adc_capture_array: ADC history is recorded and the expected
// beat stream is rebuilt from strobe cycles, then compared with what the DUT emits.
module tb_adc_capture_array;
   localparam int NUM_CH = 4, DATA_W = 128, DEPTH = 1024, DECIM_W = 8;
   localparam int LW = $clog2(DEPTH) + 1;

   logic                     pl_clk = 0, rst = 1, trigger = 0, flush = 0;
   logic [NUM_CH-1:0]        ch_enable = '0;
   logic [LW-1:0]            capture_len = '0;
   logic [DECIM_W-1:0]       decim = '0;
   logic [NUM_CH*DATA_W-1:0] s_axis_tdata = '0;
   logic [NUM_CH-1:0]        s_axis_tvalid = '0, s_axis_tready;
   logic [DATA_W-1:0]        m_axis_tdata;
   logic                     m_axis_tvalid, m_axis_tready = 1, m_axis_tlast, busy, done;
   logic [1:0]               m_axis_tuser;

   adc_capture_array #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .DECIM_W(DECIM_W)) dut (
      .pl_clk(pl_clk), .rst(rst), .trigger(trigger), .flush(flush), .ch_enable(ch_enable),
      .capture_len(capture_len), .decim(decim), .s_axis_tdata(s_axis_tdata),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
      .m_axis_tuser(m_axis_tuser), .busy(busy), .done(done));

   always #5 pl_clk = ~pl_clk;

   int n_cmp = 0, n_bad = 0;
   int cyc = 0, gn = 0, vmode = 0, rmode = 0, gap_lo = -1, gap_hi = -1;
   bit rec = 0;
   logic [NUM_CH-1:0]        hist_v[$];
   logic [NUM_CH*DATA_W-1:0] hist_d[$];
   logic [DATA_W-1:0]        got_d[$], exp_d[$];
   logic                     got_l[$], exp_l[$];
   logic [1:0]               got_u[$], exp_u[$];
   int done_cnt, done_cyc, last_acc, busy_cyc, vld_cyc, stall_viol, t_edge;
   bit done_busy, busy_seen, vld_seen, stall_prev;
   logic [DATA_W-1:0] p_data;
   logic p_last;
   logic [1:0] p_user;

   always @(posedge pl_clk) cyc <= cyc + 1;

   // ADC sources: sample index gn advances only on cycles where every channel is valid.
   always @(posedge pl_clk) begin
      logic [NUM_CH-1:0] v;
      #3;
      for (int k = 0; k < NUM_CH; k++) begin
         if (vmode == 1)      v[k] = ($urandom % 5) != 0;
         else if (vmode == 2) v[k] = !(k == 1 && cyc >= gap_lo && cyc < gap_hi);
         else                 v[k] = 1'b1;
         s_axis_tdata[k*DATA_W +: DATA_W] = {$urandom, $urandom, $urandom, 32'(k*256 + gn)};
      end
      s_axis_tvalid = v;
      if (&v) gn++;
      m_axis_tready = (rmode != 0) ? 1'($urandom % 2) : 1'b1;
   end

   always @(negedge pl_clk) begin
      if (rec) begin hist_v.push_back(s_axis_tvalid); hist_d.push_back(s_axis_tdata); end
      if (m_axis_tvalid && m_axis_tready) begin
         got_d.push_back(m_axis_tdata); got_l.push_back(m_axis_tlast); got_u.push_back(m_axis_tuser);
         last_acc = cyc;
      end
      if (done) begin
         done_cnt++;
         if (done_cnt == 1) begin done_cyc = cyc; done_busy = busy; end
      end
      if (busy && !busy_seen) begin busy_seen = 1; busy_cyc = cyc; end
      if (m_axis_tvalid && !vld_seen) begin vld_seen = 1; vld_cyc = cyc; end
      if (stall_prev && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== p_data ||
                         m_axis_tlast !== p_last || m_axis_tuser !== p_user)) stall_viol++;
      stall_prev = m_axis_tvalid && !m_axis_tready;
      p_data = m_axis_tdata; p_last = m_axis_tlast; p_user = m_axis_tuser;
   end

   // Reference: every (decim+1)-th all-enabled-valid cycle from the edge is stored.
   function automatic void build_exp(input logic [NUM_CH-1:0] en, input int dec, input int clen);
      int len, strobes[$];
      logic [NUM_CH*DATA_W-1:0] w;
      len = (clen > DEPTH) ? DEPTH : clen;
      exp_d.delete(); exp_l.delete(); exp_u.delete();
      foreach (hist_v[i]) if ((hist_v[i] & en) == en) strobes.push_back(i);
      for (int ch = 0; ch < NUM_CH; ch++) begin
         if (!en[ch]) continue;
         for (int a = 0; a < len; a++) begin
            w = (a*(dec+1) < strobes.size()) ? hist_d[strobes[a*(dec+1)]] : '0;
            exp_d.push_back(w[ch*DATA_W +: DATA_W]);
            exp_l.push_back(a == len - 1);
            exp_u.push_back(2'(ch));
         end
      end
   endfunction

   function automatic int first_bad();
      for (int i = 0; i < got_d.size() && i < exp_d.size(); i++)
         if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i] || got_u[i] !== exp_u[i]) return i;
      return -1;
   endfunction

   task automatic arm(input logic [NUM_CH-1:0] en, input int dec, input int clen);
      @(posedge pl_clk); #1;
      ch_enable = en; decim = 8'(dec); capture_len = LW'(clen);
      got_d.delete(); got_l.delete(); got_u.delete(); hist_v.delete(); hist_d.delete();
      done_cnt = 0; busy_seen = 0; vld_seen = 0; stall_viol = 0; last_acc = -1;
      gn = 0; rec = 1; trigger = 1; t_edge = cyc;
   endtask

   task automatic wait_done(input int budget, output bit to);
      to = 1;
      for (int i = 0; i < budget; i++) begin
         @(posedge pl_clk);
         if (done_cnt > 0) begin to = 0; break; end
      end
      #1; trigger = 0; rec = 0;
      repeat (4) @(posedge pl_clk);
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (3) @(posedge pl_clk);
      @(negedge pl_clk);
      n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_bad++; $display("FAIL rst_tvalid got %b want 0", m_axis_tvalid); end
      n_cmp++; if (m_axis_tlast !== 1'b0) begin n_bad++; $display("FAIL rst_tlast got %b want 0", m_axis_tlast); end
      n_cmp++; if (m_axis_tuser !== 2'd0) begin n_bad++; $display("FAIL rst_tuser got %0d want 0", m_axis_tuser); end
      n_cmp++; if (m_axis_tdata !== '0) begin n_bad++; $display("FAIL rst_tdata got %h want 0", m_axis_tdata); end
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL rst_busy_done got %b%b want 00", busy, done); end
      n_cmp++; if (s_axis_tready !== 4'hF) begin n_bad++; $display("FAIL rst_s_tready got %h want f", s_axis_tready); end
      @(posedge pl_clk); #1; rst = 0;
      repeat (2) @(posedge pl_clk);
   endtask

   // Full 4-channel ramp of 8 words; rm selects random backpressure.
   task automatic test_ramp(input int rm, input string tag);
      bit to;
      int bad;
      logic [31:0] lo;
      rmode = rm; vmode = 0;
      arm(4'hF, 0, 8);
      wait_done(2000, to);
      rmode = 0;
      build_exp(4'hF, 0, 8);
      n_cmp++; if (to) begin n_bad++; $display("FAIL %s_timeout got no done want done", tag); end
      n_cmp++; if (got_d.size() != 32) begin n_bad++; $display("FAIL %s_count got %0d want 32", tag, got_d.size()); end
      bad = first_bad();
      n_cmp++; if (bad != -1) begin n_bad++; $display("FAIL %s_model beat %0d got %h/%b/%0d want %h/%b/%0d", tag, bad, got_d[bad], got_l[bad], got_u[bad], exp_d[bad], exp_l[bad], exp_u[bad]); end
      bad = -1;
      foreach (got_d[i]) begin
         lo = got_d[i][31:0];
         if (bad < 0 && (lo !== 32'((i/8)*256 + i%8) || got_l[i] !== (i%8 == 7) || got_u[i] !== 2'(i/8))) bad = i;
      end
      n_cmp++; if (bad != -1) begin n_bad++; $display("FAIL %s_ramp beat %0d got %h want %h", tag, bad, got_d[bad][31:0], 32'((bad/8)*256 + bad%8)); end
      n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL %s_done_cnt got %0d want 1", tag, done_cnt); end
      n_cmp++; if (busy_cyc != t_edge + 1) begin n_bad++; $display("FAIL %s_busy_lat got %0d want %0d", tag, busy_cyc - t_edge, 1); end
      n_cmp++; if (done_cyc != last_acc + 1 || done_busy !== 1'b0) begin n_bad++; $display("FAIL %s_done_lat got %0d busy %b want 1 busy 0", tag, done_cyc - last_acc, done_busy); end
      n_cmp++; if (stall_viol != 0) begin n_bad++; $display("FAIL %s_stall_stable got %0d want 0", tag, stall_viol); end
      if (rm == 0) begin
         n_cmp++; if (vld_cyc - busy_cyc != 10) begin n_bad++; $display("FAIL %s_read_lat got %0d want 10", tag, vld_cyc - busy_cyc); end
      end
   endtask

   task automatic test_decim();
      bit to;
      int bad;
      logic [31:0] lo;
      vmode = 0;
      arm(4'b0101, 2, 4);
      wait_done(2000, to);
      build_exp(4'b0101, 2, 4);
      n_cmp++; if (to || got_d.size() != 8) begin n_bad++; $display("FAIL decim_count got %0d want 8", got_d.size()); end
      bad = -1;
      foreach (got_d[i]) begin
         lo = got_d[i][31:0];
         if (bad < 0 && (lo !== 32'((i/4)*512 + (i%4)*3) || got_u[i] !== 2'((i/4)*2))) bad = i;
      end
      n_cmp++; if (bad != -1) begin n_bad++; $display("FAIL decim_values beat %0d got %h want %h", bad, got_d[bad][31:0], 32'((bad/4)*512 + (bad%4)*3)); end
      bad = first_bad();
      n_cmp++; if (bad != -1) begin n_bad++; $display("FAIL decim_model beat %0d got %h want %h", bad, got_d[bad], exp_d[bad]); end
   endtask

   task automatic test_valid_gap();
      bit to;
      int bad;
      logic [31:0] lo;
      vmode = 2;
      arm(4'hF, 0, 8);
      gap_lo = t_edge + 3; gap_hi = t_edge + 6;
      wait_done(2000, to);
      vmode = 0;
      bad = -1;
      foreach (got_d[i]) begin
         lo = got_d[i][31:0];
         if (bad < 0 && lo !== 32'((i/8)*256 + i%8)) bad = i;
      end
      n_cmp++; if (to || got_d.size() != 32 || bad != -1) begin n_bad++; $display("FAIL gap_contig beat %0d count %0d want 32 contiguous", bad, got_d.size()); end
      n_cmp++; if (vld_cyc - busy_cyc != 13) begin n_bad++; $display("FAIL gap_capture_len got %0d want 13", vld_cyc - busy_cyc); end
   endtask

   task automatic test_flush();
      bit to;
      vmode = 0; rmode = 0;
      arm(4'hF, 0, 8);
      to = 1;
      for (int i = 0; i < 200; i++) begin
         @(posedge pl_clk);
         if (got_d.size() >= 5) begin to = 0; break; end
      end
      #1; flush = 1;
      @(posedge pl_clk); #1; flush = 0;
      @(negedge pl_clk);
      n_cmp++; if (to || m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL flush_stop got tvalid %b busy %b want 0 0", m_axis_tvalid, busy); end
      repeat (20) @(posedge pl_clk);
      n_cmp++; if (done_cnt != 0 || got_d.size() > 6) begin n_bad++; $display("FAIL flush_quiet got done %0d beats %0d want 0 <=6", done_cnt, got_d.size()); end
      #1; trigger = 0; rec = 0;
      repeat (3) @(posedge pl_clk);
      test_ramp(0, "post_flush");
   endtask

   task automatic test_len_edges();
      bit to;
      int bad, nl;
      arm(4'hF, 0, 0);
      wait_done(50, to);
      n_cmp++; if (to || done_cyc != t_edge + 1 || got_d.size() != 0) begin n_bad++; $display("FAIL len0 got done_lat %0d beats %0d want 1 0", done_cyc - t_edge, got_d.size()); end
      arm(4'b1001, 0, DEPTH + 1);
      wait_done(6000, to);
      build_exp(4'b1001, 0, DEPTH + 1);
      nl = 0;
      foreach (got_l[i]) if (got_l[i]) nl++;
      n_cmp++; if (to || got_d.size() != 2*DEPTH || nl != 2) begin n_bad++; $display("FAIL len_clip got beats %0d tlasts %0d want %0d 2", got_d.size(), nl, 2*DEPTH); end
      bad = first_bad();
      n_cmp++; if (bad != -1) begin n_bad++; $display("FAIL len_clip_model beat %0d got %h want %h", bad, got_d[bad], exp_d[bad]); end
   endtask

   task automatic test_retrigger();
      bit to;
      arm(4'hF, 0, 8);
      repeat (3) @(posedge pl_clk);
      #1; trigger = 0; @(posedge pl_clk); #1; trigger = 1;
      for (int i = 0; i < 100 && !vld_seen; i++) @(posedge pl_clk);
      #1; trigger = 0; @(posedge pl_clk); #1; trigger = 1;
      for (int i = 0; i < 500 && done_cnt == 0; i++) @(posedge pl_clk);
      repeat (30) @(posedge pl_clk);
      build_exp(4'hF, 0, 8);
      n_cmp++; if (got_d.size() != 32 || done_cnt != 1 || busy !== 1'b0) begin n_bad++; $display("FAIL retrigger got beats %0d done %0d busy %b want 32 1 0", got_d.size(), done_cnt, busy); end
      n_cmp++; if (first_bad() != -1) begin n_bad++; $display("FAIL retrigger_model got mismatch at %0d want none", first_bad()); end
      wait_done(1, to);
   endtask

   task automatic test_random();
      bit to;
      int bad, dec, clen;
      logic [NUM_CH-1:0] en;
      for (int it = 0; it < 8; it++) begin
         en = 4'($urandom_range(1, 15)); dec = $urandom_range(0, 3); clen = $urandom_range(1, 12);
         vmode = 1; rmode = $urandom % 2;
         arm(en, dec, clen);
         wait_done(4000, to);
         vmode = 0; rmode = 0;
         build_exp(en, dec, clen);
         bad = first_bad();
         n_cmp++; if (to || got_d.size() != exp_d.size() || bad != -1) begin n_bad++; $display("FAIL random%0d en %h dec %0d len %0d got beats %0d bad %0d want %0d -1", it, en, dec, clen, got_d.size(), bad, exp_d.size()); end
         n_cmp++; if (stall_viol != 0 || done_cnt != 1) begin n_bad++; $display("FAIL random%0d_ctrl got stall %0d done %0d want 0 1", it, stall_viol, done_cnt); end
      end
   endtask

   initial begin
      test_reset();
      test_ramp(0, "full");
      test_decim();
      test_ramp(1, "backpressure");
      test_valid_gap();
      test_flush();
      test_len_edges();
      test_retrigger();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/adc_capture_array.md
# adc_capture_array

Multi-channel, parametrised ADC capture engine for the PL fabric. On a trigger edge it records a programmable number of samples from up to NUM_CH ADC streams into per-channel block RAM, with optional decimation. It then reads the channels out, lowest enabled channel first, onto a single AXI-Stream master tagged with channel ID and per-channel tlast. The output feeds the PL-to-PS stream converter, and a flush path discards a capture in progress.

## Interface
- NUM_CH, 4: number of ADC input channels (1..8)
- DATA_W, 128: bits per ADC word (one AXIS beat)
- DEPTH, 1024: words of storage per channel; power of two
- DECIM_W, 8: width of decimation control
- pl_clk  in  1  single clock for all logic
- rst  in  1  synchronous, active-high reset
- trigger  in  1  capture start; rising edge detected internally
- flush  in  1  abort; return to IDLE and drop all buffered data
- ch_enable  in  NUM_CH  channel mask; sampled at trigger edge
- capture_len  in  $clog2(DEPTH)+1  words per channel; sampled at trigger edge
- decim  in  DECIM_W  store 1 word per decim+1 strobes; sampled at trigger edge
- s_axis_tdata  in  NUM_CH*DATA_W  ADC words; channel k at bits [k*DATA_W +: DATA_W]
- s_axis_tvalid  in  NUM_CH  per-channel valid
- s_axis_tready  out  NUM_CH  tied all-ones; the block never stalls the ADC
- m_axis_tdata  out  DATA_W  readout data
- m_axis_tvalid  out  1  readout valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last word of the current channel
- m_axis_tuser  out  max(1,$clog2(NUM_CH))  channel ID of the current word
- busy  out  1  high in CAPTURE or READOUT
- done  out  1  one-cycle pulse when a capture/readout completes

## Operation
- Input data and valid are registered once before use, so every word is captured one cycle after it arrives.
- Trigger is registered. An edge is a cycle with trigger=1 and the previous trigger=0. Holding trigger high never retriggers.
- States are IDLE, CAPTURE, READOUT and DONE.
- IDLE -> CAPTURE on an edge when the latched ch_enable is not zero. An edge with ch_enable=0 is ignored.
- At the edge, the block latches ch_enable, decim and len. len = min(capture_len, DEPTH).
- If len=0, IDLE -> DONE and nothing is read out.
- In CAPTURE, a strobe occurs on each cycle in which every enabled channel's registered tvalid is 1.
- The decimation counter starts at 0 and counts strobes only. A word is written when the counter is 0, and the counter wraps at decim.
- On a cycle where any enabled channel is invalid, nothing is written and the counter holds.
- Each write stores all enabled channels at the same address, then increments the address.
- When the address reaches len: CAPTURE -> READOUT.
- In READOUT, each enabled channel is read in ascending index order, addresses 0..len-1. The memory has synchronous read, followed by an output register.
- m_axis_tuser carries the channel index. tlast is 1 on address len-1.
- After the last word of the highest enabled channel is accepted (tvalid && tready): READOUT -> DONE.
- DONE -> IDLE after one cycle. done is 1 only while in DONE.
- Edges during CAPTURE, READOUT or DONE are ignored.
- flush has priority over everything except rst. From any state, flush -> IDLE next cycle with m_axis_tvalid=0. The memory contents are left stale but are never emitted.
- rst mid-operation has the same effect as flush, and also clears all registers to their reset values.

## Timing
- Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, busy=0, done=0, s_axis_tready=all 1, state=IDLE.
- Edge in cycle t -> busy=1 at t+1. The first stored word is s_axis_tdata presented at cycle t.
- With decim=0 and continuous valid, CAPTURE lasts exactly len cycles.
- Readout latency: READOUT entered at cycle r -> first m_axis_tvalid=1 at r+2.
- Readout throughput is 1 word/cycle while tready=1, including across channel boundaries with no bubble.
- While tvalid=1 and tready=0, tdata, tlast and tuser must hold stable. The read pipeline stalls and no word is lost or duplicated.
- Final accept at cycle a -> done=1 at a+1 and busy=0 at a+1.

## Test plan
- NUM_CH=4, decim=0, capture_len=8, ch_enable=4'hF, channel k driving the ramp k*256+n -> 32 beats: ch0 values 0..7, then ch1 256..263, and so on. tlast on beats 8, 16, 24 and 32. tuser 0,0..3. Exactly one done pulse.
- ch_enable=4'b0101, decim=2, capture_len=4 -> only ch0 and ch2 are emitted, with values n=0,3,6,9 (plus k*256).
- Same as the first scenario with m_axis_tready randomly 50% low -> identical beat sequence, and outputs stable throughout every stall.
- ch1 tvalid low for 3 cycles mid-capture -> every channel's stored sequence is still contiguous in n, with no sample skipped. CAPTURE lasts 3 cycles longer (busy rise to READOUT entry = 8+3 cycles).
- flush asserted after 5 readout beats -> m_axis_tvalid=0 and busy=0 on the next cycle. A later trigger yields a complete, correct 32-beat capture.
- capture_len=0 -> done pulses 1 cycle after the edge with no beats output. capture_len=DEPTH+1 -> DEPTH beats per channel. A second edge while busy -> ignored, and no extra beats are output.
